// File: rtl/ov7670_dvp_emulator.sv
// OV7670-style DVP camera transmitter: pclk/vsync/href plus RGB565 test patterns,
// with VGA frame timing scaled by parameters so it can stand in for the sensor.
module ov7670_dvp_emulator #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int H_BLANK_BYTES  = 288,
  parameter int VSYNC_LINES    = 3,
  parameter int V_BACK_LINES   = 17,
  parameter int V_FRONT_LINES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  data_o,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o
);

  localparam int LINE_BYTES   = 2 * ACTIVE_COLUMNS + H_BLANK_BYTES;
  localparam int ACTIVE_BYTES = 2 * ACTIVE_COLUMNS;
  localparam int BAR_WIDTH    = ACTIVE_COLUMNS / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t      state_r;
  logic [15:0] byte_cnt_r;
  logic [15:0] line_cnt_r;
  logic [1:0]  pattern_r;
  logic [15:0] state_lines_s;
  logic [15:0] pixel_x_s;
  logic [15:0] pixel_s;
  logic [2:0]  bar_s;
  logic [7:0]  byte_s;
  logic        last_byte_s;
  logic        last_line_s;
  logic        href_s;

  // Number of lines spent in the current state before moving on.
  always_comb begin
    state_lines_s = 16'd1;
    case (state_r)
      ST_VSYNC:  state_lines_s = 16'(VSYNC_LINES);
      ST_VBACK:  state_lines_s = 16'(V_BACK_LINES);
      ST_ACTIVE: state_lines_s = 16'(ACTIVE_ROWS);
      ST_VFRONT: state_lines_s = 16'(V_FRONT_LINES);
      default:   state_lines_s = 16'd1;
    endcase
  end

  assign last_byte_s = (byte_cnt_r == 16'(LINE_BYTES - 1));
  assign last_line_s = (line_cnt_r == (state_lines_s - 16'd1));
  assign href_s      = (state_r == ST_ACTIVE) && (byte_cnt_r < 16'(ACTIVE_BYTES));
  assign pixel_x_s   = {1'b0, byte_cnt_r[15:1]};
  assign bar_s       = 3'(pixel_x_s / 16'(BAR_WIDTH));

  // RGB565 colour of the pixel addressed by the counters, for the frame's latched pattern.
  always_comb begin
    pixel_s = 16'h0000;
    case (pattern_r)
      2'd0: begin
        case (bar_s)
          3'd0:    pixel_s = 16'hFFFF;
          3'd1:    pixel_s = 16'hFFE0;
          3'd2:    pixel_s = 16'h07FF;
          3'd3:    pixel_s = 16'h07E0;
          3'd4:    pixel_s = 16'hF81F;
          3'd5:    pixel_s = 16'hF800;
          3'd6:    pixel_s = 16'h001F;
          3'd7:    pixel_s = 16'h0000;
          default: pixel_s = 16'h0000;
        endcase
      end
      2'd1:    pixel_s = {pixel_x_s[9:5], pixel_x_s[9:4], pixel_x_s[9:5]};
      2'd2:    pixel_s = (pixel_x_s[5] ^ line_cnt_r[5]) ? 16'h0000 : 16'hFFFF;
      2'd3:    pixel_s = 16'hFFFF;
      default: pixel_s = 16'h0000;
    endcase
  end

  assign byte_s = byte_cnt_r[0] ? pixel_s[7:0] : pixel_s[15:8];

  // Pixel clock, frame sequencer and bus registers; bus fields change only on the
  // pclk falling edge so they are stable around the receiver's rising-edge sample.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pclk_o        <= 1'b0;
      vsync_o       <= 1'b0;
      href_o        <= 1'b0;
      data_o        <= 8'h00;
      frame_done_o  <= 1'b0;
      frame_count_o <= 16'h0000;
      state_r       <= ST_IDLE;
      byte_cnt_r    <= 16'd0;
      line_cnt_r    <= 16'd0;
      pattern_r     <= 2'd0;
    end else begin
      pclk_o       <= ~pclk_o;
      frame_done_o <= 1'b0;
      if (pclk_o) begin
        vsync_o <= (state_r == ST_VSYNC);
        href_o  <= href_s;
        data_o  <= href_s ? byte_s : 8'h00;
        if (state_r == ST_IDLE) begin
          byte_cnt_r <= 16'd0;
          line_cnt_r <= 16'd0;
          if (enable_i) begin
            state_r   <= ST_VSYNC;
            pattern_r <= pattern_sel_i;
          end else begin
            state_r <= ST_IDLE;
          end
        end else if (!last_byte_s) begin
          byte_cnt_r <= byte_cnt_r + 16'd1;
        end else begin
          byte_cnt_r <= 16'd0;
          if (!last_line_s) begin
            line_cnt_r <= line_cnt_r + 16'd1;
          end else begin
            line_cnt_r <= 16'd0;
            case (state_r)
              ST_VSYNC:  state_r <= ST_VBACK;
              ST_VBACK:  state_r <= ST_ACTIVE;
              ST_ACTIVE: state_r <= ST_VFRONT;
              ST_VFRONT: begin
                frame_done_o  <= 1'b1;
                frame_count_o <= frame_count_o + 16'd1;
                if (enable_i) begin
                  state_r   <= ST_VSYNC;
                  pattern_r <= pattern_sel_i;
                end else begin
                  state_r <= ST_IDLE;
                end
              end
              default:   state_r <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Scoreboard bench for ov7670_dvp_emulator using a scaled frame (64x34 active,
// 8 blank bytes per line, 2/2/2 vertical blank lines) to keep runs short.
`timescale 1ns/1ps
module tb_ov7670_dvp_emulator;

  localparam int AC = 64;
  localparam int AR = 34;
  localparam int HB = 8;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int AB = 2 * AC;
  localparam int LB = AB + HB;
  localparam int FL = VS + VB + AR + VF;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [1:0]  pattern_sel_i;
  logic        pclk_o;
  logic        vsync_o;
  logic        href_o;
  logic [7:0]  data_o;
  logic        frame_done_o;
  logic [15:0] frame_count_o;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int done_pulses = 0;
  int mon_line = 0;
  int mon_byte = 0;
  logic href_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] cap [0:AR-1][0:AB-1];

  ov7670_dvp_emulator #(
    .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR), .H_BLANK_BYTES(HB),
    .VSYNC_LINES(VS), .V_BACK_LINES(VB), .V_FRONT_LINES(VF)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .pattern_sel_i(pattern_sel_i),
    .pclk_o(pclk_o), .vsync_o(vsync_o), .href_o(href_o), .data_o(data_o),
    .frame_done_o(frame_done_o), .frame_count_o(frame_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_pixel(input logic [1:0] pat, input int x, input int y);
    int r;
    int g;
    case (pat)
      2'd0: begin
        case (x / (AC / 8))
          0:       return 16'hFFFF;
          1:       return 16'hFFE0;
          2:       return 16'h07FF;
          3:       return 16'h07E0;
          4:       return 16'hF81F;
          5:       return 16'hF800;
          6:       return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: begin
        r = x / 32;
        g = x / 16;
        return 16'((r << 11) | (g << 5) | r);
      end
      2'd2:    return (((x / 32) % 2) == ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] pat);
    logic [15:0] p;
    for (int y = 0; y < AR; y++) begin
      for (int x = 0; x < AC; x++) begin
        p = model_pixel(pat, x, y);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  // Advance to the next sample point in the middle of a pclk-high half period.
  task automatic next_byte();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pclk_o && k < 4);
  endtask

  // Receiver-side monitor: pops expected bytes while href is high.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (frame_done_o) done_pulses++;
      if (pclk_o) begin
        if (vsync_o) begin
          mon_line = 0;
          mon_byte = 0;
          chk_cnt++;
          if (href_o !== 1'b0) $display("FAIL sync_overlap: href=%b while vsync=1, required 0", href_o);
          else pass_cnt++;
        end
        if (href_o) begin
          chk_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_underflow: got byte %h with no expected byte queued", data_o);
          end else begin
            e = exp_q.pop_front();
            if (data_o !== e) $display("FAIL data line %0d byte %0d: got %h required %h", mon_line, mon_byte, data_o, e);
            else pass_cnt++;
          end
          if (mon_line < AR && mon_byte < AB) cap[mon_line][mon_byte] = data_o;
          mon_byte++;
        end else begin
          if (href_prev) begin
            mon_line++;
            mon_byte = 0;
          end
          chk_cnt++;
          if (data_o !== 8'h00) $display("FAIL data_blank: got %h required 00", data_o);
          else pass_cnt++;
        end
        href_prev = href_o;
      end
    end
  end

  task automatic test_reset();
    logic pclk_prev = 1'b0;
    reset_i = 1'b1; enable_i = 1'b0; pattern_sel_i = 2'd0;
    #2 reset_i = 1'b0;
    #10;
    chk_cnt++;
    if ({pclk_o, vsync_o, href_o, data_o, frame_done_o, frame_count_o} !== 28'd0)
      $display("FAIL reset_outputs: got %h required 0", {pclk_o, vsync_o, href_o, data_o, frame_done_o, frame_count_o});
    else pass_cnt++;
    @(negedge clk);
    reset_i = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk_cnt++;
      if (pclk_o !== ~pclk_prev) $display("FAIL idle_pclk: got %b required %b", pclk_o, ~pclk_prev);
      else pass_cnt++;
      pclk_prev = pclk_o;
      chk_cnt++;
      if ({vsync_o, href_o, data_o} !== 10'd0) $display("FAIL idle_outputs: got %h required 0", {vsync_o, href_o, data_o});
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_timing();
    int t = 0;
    int w;
    int pulses = 0;
    int d0;
    pattern_sel_i = 2'd0;
    push_frame(2'd0);
    enable_i = 1'b1;
    d0 = done_pulses;
    while (!vsync_o && t < 4 * LB) begin next_byte(); t++; end
    chk_cnt++;
    if (vsync_o !== 1'b1) $display("FAIL vsync_start: got %b required 1 within %0d byte periods", vsync_o, 4 * LB);
    else pass_cnt++;
    t = 0;
    while (vsync_o && t < FL * LB) begin next_byte(); t++; end
    chk_cnt++;
    if (t !== VS * LB) $display("FAIL vsync_width: got %0d required %0d", t, VS * LB);
    else pass_cnt++;
    while (!href_o && t < FL * LB) begin next_byte(); t++; end
    chk_cnt++;
    if (t !== (VS + VB) * LB) $display("FAIL first_href: got %0d required %0d", t, (VS + VB) * LB);
    else pass_cnt++;
    while (!vsync_o && t < 2 * FL * LB) begin
      if (href_o) begin
        w = 0;
        while (href_o && w < LB) begin next_byte(); w++; t++; end
        pulses++;
        chk_cnt++;
        if (w !== AB) $display("FAIL href_width line %0d: got %0d required %0d", pulses, w, AB);
        else pass_cnt++;
        if (pulses == 10) begin
          pattern_sel_i = 2'd2;
          push_frame(2'd2);
        end
      end else begin
        next_byte();
        t++;
      end
    end
    chk_cnt++;
    if (t !== FL * LB) $display("FAIL frame_length: got %0d required %0d", t, FL * LB);
    else pass_cnt++;
    chk_cnt++;
    if (pulses !== AR) $display("FAIL href_pulses: got %0d required %0d", pulses, AR);
    else pass_cnt++;
    chk_cnt++;
    if (done_pulses - d0 !== 1) $display("FAIL frame_done_count: got %0d required 1", done_pulses - d0);
    else pass_cnt++;
    chk_cnt++;
    if (frame_count_o !== 16'd1) $display("FAIL frame_count_1: got %0d required 1", frame_count_o);
    else pass_cnt++;
    chk_cnt++;
    if ({cap[0][0], cap[0][1], cap[0][16], cap[0][17]} !== 32'hFFFF_FFE0)
      $display("FAIL bars_white_yellow: got %h required ffffffe0", {cap[0][0], cap[0][1], cap[0][16], cap[0][17]});
    else pass_cnt++;
    chk_cnt++;
    if ({cap[0][96], cap[0][97], cap[0][126], cap[0][127]} !== 32'h001F_0000)
      $display("FAIL bars_blue_black: got %h required 001f0000", {cap[0][96], cap[0][97], cap[0][126], cap[0][127]});
    else pass_cnt++;
  endtask

  task automatic test_checkerboard();
    int n = 0;
    while (vsync_o && n < FL * LB) begin next_byte(); n++; end
    pattern_sel_i = 2'd1;
    push_frame(2'd1);
    while (!vsync_o && n < 2 * FL * LB) begin next_byte(); n++; end
    chk_cnt++;
    if (n !== FL * LB) $display("FAIL back_to_back_frame: got %0d required %0d", n, FL * LB);
    else pass_cnt++;
    chk_cnt++;
    if ({cap[0][0], cap[0][1], cap[0][64], cap[0][65]} !== 32'hFFFF_0000)
      $display("FAIL checker_row0: got %h required ffff0000", {cap[0][0], cap[0][1], cap[0][64], cap[0][65]});
    else pass_cnt++;
    chk_cnt++;
    if ({cap[32][0], cap[32][1], cap[32][64], cap[32][65]} !== 32'h0000_FFFF)
      $display("FAIL checker_row32: got %h required 0000ffff", {cap[32][0], cap[32][1], cap[32][64], cap[32][65]});
    else pass_cnt++;
    chk_cnt++;
    if (frame_count_o !== 16'd2) $display("FAIL frame_count_2: got %0d required 2", frame_count_o);
    else pass_cnt++;
  endtask

  task automatic test_gradient_disable();
    int n = 0;
    int pulses = 0;
    int seen = 0;
    int d0;
    logic hprev = 1'b0;
    while (pulses < 10 && n < FL * LB) begin
      next_byte();
      n++;
      if (href_o && !hprev) pulses++;
      hprev = href_o;
    end
    enable_i = 1'b0;
    pattern_sel_i = 2'd3;
    d0 = done_pulses;
    n = 0;
    while (done_pulses == d0 && n < FL * LB) begin next_byte(); n++; end
    chk_cnt++;
    if (done_pulses - d0 !== 1) $display("FAIL disable_done: got %0d pulses required 1", done_pulses - d0);
    else pass_cnt++;
    chk_cnt++;
    if (frame_count_o !== 16'd3) $display("FAIL frame_count_3: got %0d required 3", frame_count_o);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d bytes required 0", exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if ({cap[0][64], cap[0][65], cap[0][126], cap[0][127]} !== 32'h0841_0861)
      $display("FAIL gradient: got %h required 08410861", {cap[0][64], cap[0][65], cap[0][126], cap[0][127]});
    else pass_cnt++;
    repeat (3 * LB) begin
      next_byte();
      if (vsync_o || href_o) seen++;
    end
    chk_cnt++;
    if (seen !== 0) $display("FAIL idle_after_disable: got %0d active samples required 0", seen);
    else pass_cnt++;
    chk_cnt++;
    if (done_pulses - d0 !== 1) $display("FAIL done_single: got %0d pulses required 1", done_pulses - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_active();
    int n = 0;
    int pulses = 0;
    int d0;
    logic hprev = 1'b0;
    pattern_sel_i = 2'd3;
    push_frame(2'd3);
    enable_i = 1'b1;
    while (pulses < 5 && n < FL * LB + 4 * LB) begin
      next_byte();
      n++;
      if (href_o && !hprev) pulses++;
      hprev = href_o;
    end
    #2 reset_i = 1'b0;
    #1;
    chk_cnt++;
    if ({pclk_o, vsync_o, href_o, data_o, frame_done_o, frame_count_o} !== 28'd0)
      $display("FAIL async_reset: got %h required 0", {pclk_o, vsync_o, href_o, data_o, frame_done_o, frame_count_o});
    else pass_cnt++;
    exp_q.delete();
    href_prev = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({pclk_o, vsync_o, href_o, data_o, frame_count_o} !== 27'd0)
      $display("FAIL reset_hold: got %h required 0", {pclk_o, vsync_o, href_o, data_o, frame_count_o});
    else pass_cnt++;
    push_frame(2'd3);
    reset_i = 1'b1;
    n = 0;
    while (!vsync_o && n < 4 * LB) begin next_byte(); n++; end
    chk_cnt++;
    if (vsync_o !== 1'b1) $display("FAIL restart_vsync: got %b required 1", vsync_o);
    else pass_cnt++;
    n = 0;
    while (vsync_o && n < FL * LB) begin next_byte(); n++; end
    chk_cnt++;
    if (n !== VS * LB) $display("FAIL restart_vsync_width: got %0d required %0d", n, VS * LB);
    else pass_cnt++;
    enable_i = 1'b0;
    d0 = done_pulses;
    n = 0;
    while (done_pulses == d0 && n < FL * LB) begin next_byte(); n++; end
    chk_cnt++;
    if (frame_count_o !== 16'd1) $display("FAIL restart_count: got %0d required 1", frame_count_o);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() !== 0) $display("FAIL restart_leftover: got %0d bytes required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_timing();
    test_checkerboard();
    test_gradient_disable();
    test_reset_mid_active();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
